spi_master: RTL and testbench



---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_clk_gen.sv | 71 +++++++
 rtl/spi_master.sv | 116 +++++++++++
 tb/tb_spi_master.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared SPI mode decode helpers and transfer constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int c_EDGES_PER_BYTE = 16;
    localparam int c_EDGE_CNT_W     = 5;

    function automatic logic spi_cpol(input int mode);
        return mode[1];
    endfunction

    function automatic logic spi_cpha(input int mode);
        return mode[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : spi_clk_gen
//  Description : SPI clock generator with leading/trailing edge strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter logic CPOL              = 1'b0,
    parameter int   CLKS_PER_HALF_BIT = 2
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_start,
    output logic o_lead,
    output logic o_trail,
    output logic o_spi_clk,
    output logic o_ready
);

    localparam int                      c_CNT_W     = $clog2(CLKS_PER_HALF_BIT);
    localparam logic [c_CNT_W-1:0]      c_CNT_MAX   = c_CNT_W'(CLKS_PER_HALF_BIT - 1);
    localparam logic [c_EDGE_CNT_W-1:0] c_LAST_EDGE = c_EDGE_CNT_W'(c_EDGES_PER_BYTE);

    logic [c_CNT_W-1:0]      r_half_cnt;
    logic [c_EDGE_CNT_W-1:0] r_edge_cnt;
    logic                    r_spi_clk;
    logic                    r_busy;
    logic                    r_ready;
    logic                    w_done;
    logic                    w_toggle;

    // Busy lingers one cycle after edge 16 so ready rises a cycle later.
    assign w_done    = r_busy && (r_edge_cnt == c_LAST_EDGE);
    assign w_toggle  = r_busy && !w_done && (r_half_cnt == c_CNT_MAX);
    assign o_lead    = w_toggle && !r_edge_cnt[0];
    assign o_trail   = w_toggle &&  r_edge_cnt[0];
    assign o_spi_clk = r_spi_clk;
    assign o_ready   = r_ready;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_half_cnt <= '0;
            r_edge_cnt <= '0;
            r_spi_clk  <= CPOL;
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
        end else if (i_start) begin
            r_half_cnt <= '0;
            r_edge_cnt <= '0;
            r_busy     <= 1'b1;
            r_ready    <= 1'b0;
        end else if (w_done) begin
            r_busy     <= 1'b0;
            r_ready    <= 1'b1;
        end else if (r_busy) begin
            if (w_toggle) begin
                r_spi_clk  <= ~r_spi_clk;
                r_edge_cnt <= r_edge_cnt + 1'b1;
                r_half_cnt <= '0;
            end else begin
                r_half_cnt <= r_half_cnt + 1'b1;
            end
        end else begin
            r_ready <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master
//  Description : Byte-oriented SPI master, MSB first, modes 0..3.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master
    import spi_pkg::*;
#(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_SPI_Clk,
    input  logic       i_SPI_MISO,
    output logic       o_SPI_MOSI
);

    localparam logic c_CPOL = spi_cpol(SPI_MODE);
    localparam logic c_CPHA = spi_cpha(SPI_MODE);

    logic       w_start;
    logic       w_lead;
    logic       w_trail;
    logic       w_ready;
    logic       w_tx_strobe;
    logic       w_rx_strobe;
    logic [7:0] r_tx_byte;
    logic [2:0] r_tx_idx;
    logic [3:0] r_tx_rem;
    logic       r_mosi;
    logic [7:0] r_rx_shift;
    logic [2:0] r_rx_cnt;
    logic       r_rx_full;
    logic [7:0] r_rx_byte;
    logic       r_rx_dv;

    spi_clk_gen #(
        .CPOL              (c_CPOL),
        .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT)
    ) u_clk_gen (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_start   (w_start),
        .o_lead    (w_lead),
        .o_trail   (w_trail),
        .o_spi_clk (o_SPI_Clk),
        .o_ready   (w_ready)
    );

    assign w_start     = i_TX_DV && w_ready;
    assign w_tx_strobe = c_CPHA ? w_lead  : w_trail;
    assign w_rx_strobe = c_CPHA ? w_trail : w_lead;

    // With CPHA=0 bit 7 is presented at acceptance, so only 7 bits remain.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_tx_byte <= 8'h00;
            r_tx_idx  <= 3'd0;
            r_tx_rem  <= 4'd0;
            r_mosi    <= 1'b0;
        end else if (w_start) begin
            r_tx_byte <= i_TX_Byte;
            if (c_CPHA) begin
                r_tx_idx <= 3'd7;
                r_tx_rem <= 4'd8;
            end else begin
                r_mosi   <= i_TX_Byte[7];
                r_tx_idx <= 3'd6;
                r_tx_rem <= 4'd7;
            end
        end else if (w_tx_strobe && (r_tx_rem != 4'd0)) begin
            r_mosi   <= r_tx_byte[r_tx_idx];
            r_tx_idx <= r_tx_idx - 1'b1;
            r_tx_rem <= r_tx_rem - 1'b1;
        end
    end

    // The full byte is published one cycle after the 8th sample.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_rx_shift <= 8'h00;
            r_rx_cnt   <= 3'd0;
            r_rx_full  <= 1'b0;
            r_rx_byte  <= 8'h00;
            r_rx_dv    <= 1'b0;
        end else begin
            r_rx_dv   <= 1'b0;
            r_rx_full <= 1'b0;
            if (w_start) begin
                r_rx_cnt <= 3'd0;
            end else if (w_rx_strobe) begin
                r_rx_shift <= {r_rx_shift[6:0], i_SPI_MISO};
                r_rx_cnt   <= r_rx_cnt + 1'b1;
                r_rx_full  <= (r_rx_cnt == 3'd7);
            end
            if (r_rx_full) begin
                r_rx_byte <= r_rx_shift;
                r_rx_dv   <= 1'b1;
            end
        end
    end

    assign o_TX_Ready = w_ready;
    assign o_RX_DV    = r_rx_dv;
    assign o_RX_Byte  = r_rx_byte;
    assign o_SPI_MOSI = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master
//  Description : Self-checking bench, one loopback instance per SPI mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      txdv_v;
    logic [3:0]      ready_v;
    logic [3:0]      rxdv_v;
    logic [3:0]      spiclk_v;
    logic [3:0]      mosi_v;
    logic [3:0]      miso_v;
    logic [3:0][7:0] txbyte_v;
    logic [3:0][7:0] rxbyte_v;
    int              n_cmp = 0;
    int              n_bad = 0;

    always #5 clk = ~clk;

    assign miso_v = mosi_v;

    // Instance g runs SPI mode g; odd modes use 4 clocks per half bit.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_master #(
            .SPI_MODE          (g),
            .CLKS_PER_HALF_BIT ((g % 2) ? 4 : 2)
        ) u_dut (
            .i_Clk      (clk),
            .i_Rst      (rst),
            .i_TX_Byte  (txbyte_v[g]),
            .i_TX_DV    (txdv_v[g]),
            .o_TX_Ready (ready_v[g]),
            .o_RX_DV    (rxdv_v[g]),
            .o_RX_Byte  (rxbyte_v[g]),
            .o_SPI_Clk  (spiclk_v[g]),
            .i_SPI_MISO (miso_v[g]),
            .o_SPI_MOSI (mosi_v[g])
        );
    end

    function automatic int hpb(input int i);
        return (i % 2 != 0) ? 4 : 2;
    endfunction

    function automatic logic cpol(input int i);
        return (i >= 2);
    endfunction

    function automatic logic cpha(input int i);
        return (i % 2 != 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic quiet(input int i, input int n);
        int edges = 0;
        int dvs   = 0;
        int nrdy  = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (spiclk_v[i] !== cpol(i)) edges++;
            if (rxdv_v[i] !== 1'b0) dvs++;
            if (ready_v[i] !== 1'b1) nrdy++;
        end
        chk("quiet_clk_idle", edges, 0);
        chk("quiet_ready_high", nrdy, 0);
        chk("quiet_no_rx_dv", dvs, 0);
    endtask

    // One transfer on instance i; inj>0 pulses TX_DV=FF at that cycle,
    // rst_edge>0 asserts reset once that SPI edge has been seen.
    task automatic xfer(input int i, input logic [7:0] b, input int inj, input int rst_edge);
        int         h, c, edges, dv_cnt, dv_cyc, rdy_cyc;
        logic       pclk, pmosi, lead, tim_ok, stab_ok, hit_rst;
        logic [7:0] cap, got;
        h = hpb(i);
        c = 0;
        while (ready_v[i] !== 1'b1 && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        chk("ready_before_start", ready_v[i], 1'b1);
        pclk  = spiclk_v[i];
        pmosi = mosi_v[i];
        txbyte_v[i] = b;
        txdv_v[i]   = 1'b1;
        @(posedge clk); #1;
        txdv_v[i]   = 1'b0;
        txbyte_v[i] = 8'($urandom);
        c = 1; edges = 0; dv_cnt = 0; dv_cyc = 0; rdy_cyc = 0;
        tim_ok = 1'b1; stab_ok = 1'b1; hit_rst = 1'b0; cap = 8'h00; got = 8'h00;
        chk("ready_low_after_accept", ready_v[i], 1'b0);
        forever begin
            if (spiclk_v[i] !== pclk) begin
                edges++;
                if (c != 1 + edges * h) tim_ok = 1'b0;
                lead = (spiclk_v[i] !== cpol(i));
                if (lead == !cpha(i)) begin
                    if (mosi_v[i] !== pmosi) stab_ok = 1'b0;
                    cap = {cap[6:0], mosi_v[i]};
                end
                if (edges == rst_edge) hit_rst = 1'b1;
            end
            if (rxdv_v[i] === 1'b1) begin
                dv_cnt++;
                dv_cyc = c;
                got    = rxbyte_v[i];
            end
            if (ready_v[i] === 1'b1) rdy_cyc = c;
            if (hit_rst || rdy_cyc != 0 || c >= 16 * h + 8) break;
            txdv_v[i] = (c == inj);
            if (c == inj) txbyte_v[i] = 8'hFF;
            pclk  = spiclk_v[i];
            pmosi = mosi_v[i];
            @(posedge clk); #1;
            c++;
        end
        txdv_v[i] = 1'b0;

        if (hit_rst) begin
            rst = 1'b1;
            @(posedge clk); #1;
            chk("rst_mid_ready", ready_v[i], 1'b0);
            chk("rst_mid_rx_dv", rxdv_v[i], 1'b0);
            chk("rst_mid_rx_byte", rxbyte_v[i], 8'h00);
            chk("rst_mid_mosi", mosi_v[i], 1'b0);
            chk("rst_mid_spi_clk", spiclk_v[i], cpol(i));
            chk("rst_mid_no_dv_before", dv_cnt, 0);
            rst = 1'b0;
            dv_cnt = 0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); #1;
                if (rxdv_v[i] !== 1'b0) dv_cnt++;
            end
            chk("rst_mid_no_dv_after", dv_cnt, 0);
            return;
        end

        chk("edge_count", edges, 16);
        chk("edge_timing", tim_ok, 1'b1);
        chk("mosi_stable_at_sample", stab_ok, 1'b1);
        chk("mosi_bits_msb_first", cap, b);
        chk("ready_rise_cycle", rdy_cyc, 2 + 16 * h);
        chk("rx_dv_count", dv_cnt, 1);
        chk("rx_byte_at_dv", got, b);
        chk("rx_byte_at_ready", rxbyte_v[i], b);
        chk("rx_dv_not_after_ready", (dv_cyc != 0 && dv_cyc <= rdy_cyc), 1'b1);
        if (cpha(i)) chk("rx_dv_with_ready_cpha1", dv_cyc, rdy_cyc);
        chk("spi_clk_idle", spiclk_v[i], cpol(i));
    endtask

    initial begin
        int         ri;
        logic [7:0] rb;
        rst      = 1'b1;
        txdv_v   = 4'b0000;
        txbyte_v = '0;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("reset_ready", ready_v[i], 1'b0);
            chk("reset_rx_dv", rxdv_v[i], 1'b0);
            chk("reset_rx_byte", rxbyte_v[i], 8'h00);
            chk("reset_mosi", mosi_v[i], 1'b0);
            chk("reset_spi_clk", spiclk_v[i], cpol(i));
        end
        rst = 1'b0;

        xfer(3, 8'hC1, 0, 0);
        quiet(3, 12);
        xfer(3, 8'hBE, 0, 0);
        xfer(3, 8'hEF, 0, 0);
        quiet(3, 12);

        for (int i = 0; i < 3; i++) begin
            xfer(i, 8'hA5, 0, 0);
            xfer(i, 8'h3C, 0, 0);
            quiet(i, 10);
        end

        xfer(0, 8'h55, 10, 0);
        quiet(0, 20);
        xfer(1, 8'h55, 20, 0);
        quiet(1, 20);

        xfer(1, 8'(32'($urandom)), 0, 7);
        xfer(1, 8'h96, 0, 0);
        xfer(2, 8'(32'($urandom)), 0, 7);
        xfer(2, 8'h69, 0, 0);

        for (int r = 0; r < 12; r++) begin
            ri = int'($urandom_range(0, 3));
            rb = 8'($urandom);
            xfer(ri, rb, 0, 0);
            if ($urandom_range(0, 1) == 1) quiet(ri, 6);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
